duty_ramp: RTL and testbench



---
 rtl/duty_ramp.sv | 128 ++++++++++++
 tb/tb_duty_ramp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/duty_ramp.sv
// duty_ramp: slews a registered PWM duty toward an accepted target, one LSB every STEP_DIV clocks.
// Define DUTY_RAMP_RETARGET_EN to accept new targets mid-ramp while keeping the step cadence.
module duty_ramp #(
    parameter int unsigned DUTY_W   = 4,
    parameter int unsigned DUTY_MAX = 10,
    parameter int unsigned STEP_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] tgt,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              at_target,
    output logic              clamped
);
    typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

    localparam logic [DUTY_W-1:0] MaxDuty = DUTY_W'(DUTY_MAX);
    localparam logic [15:0]       PreLast = 16'(STEP_DIV - 1);

    state_e            state_q;
    logic [DUTY_W-1:0] duty_q, target_q;
    logic [15:0]       pre_q;
    logic              busy_q, at_target_q, clamped_q;

    logic              accept, over, step_now, new_up;
    logic [DUTY_W-1:0] tgt_sat, step_next;
`ifdef DUTY_RAMP_RETARGET_EN
    logic [DUTY_W-1:0] retarget_step;
`endif

    always_comb begin
`ifdef DUTY_RAMP_RETARGET_EN
        tgt_ready = 1'b1;
`else
        tgt_ready = (state_q == StIdle);
`endif
        accept    = tgt_valid & tgt_ready;
        over      = (32'(tgt) > DUTY_MAX);
        tgt_sat   = over ? MaxDuty : tgt;
        new_up    = (tgt_sat > duty_q);
        step_now  = (state_q != StIdle) && (pre_q == PreLast);
        step_next = (state_q == StRampUp) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
`ifdef DUTY_RAMP_RETARGET_EN
        // A step landing on a retarget edge moves toward the new target, not the old one.
        retarget_step = new_up ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            duty_q      <= '0;
            target_q    <= '0;
            pre_q       <= '0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b1;
            clamped_q   <= 1'b0;
        end else begin
            clamped_q <= accept & over;
            if (accept) begin
                target_q <= tgt_sat;
            end
            if (accept && state_q == StIdle) begin
                pre_q <= '0;
                if (tgt_sat == duty_q) begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    at_target_q <= 1'b1;
                end else begin
                    state_q     <= new_up ? StRampUp : StRampDown;
                    busy_q      <= 1'b1;
                    at_target_q <= 1'b0;
                end
            end
`ifdef DUTY_RAMP_RETARGET_EN
            else if (accept) begin
                if (tgt_sat == duty_q) begin
                    state_q     <= StIdle;
                    pre_q       <= '0;
                    busy_q      <= 1'b0;
                    at_target_q <= 1'b1;
                end else if (step_now) begin
                    duty_q <= retarget_step;
                    pre_q  <= '0;
                    if (retarget_step == tgt_sat) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        at_target_q <= 1'b1;
                    end else begin
                        state_q <= new_up ? StRampUp : StRampDown;
                    end
                end else begin
                    pre_q   <= pre_q + 16'd1;
                    state_q <= new_up ? StRampUp : StRampDown;
                end
            end
`endif
            else begin
                unique case (state_q)
                    StIdle: pre_q <= '0;
                    StRampUp, StRampDown: begin
                        if (step_now) begin
                            duty_q <= step_next;
                            pre_q  <= '0;
                            if (step_next == target_q) begin
                                state_q     <= StIdle;
                                busy_q      <= 1'b0;
                                at_target_q <= 1'b1;
                            end
                        end else begin
                            pre_q <= pre_q + 16'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign duty      = duty_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;
    assign clamped   = clamped_q;

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: directed and random targets against a step-schedule reference model.
module tb_duty_ramp;
    localparam int DW   = 4;
    localparam int DMAX = 10;
    localparam int SD   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] tgt = '0;
    logic          tgt_valid = 1'b0;
    logic          tgt_ready;
    logic [DW-1:0] duty;
    logic          busy;
    logic          at_target;
    logic          clamped;

    always #5 clk = ~clk;

    duty_ramp #(
        .DUTY_W  (DW),
        .DUTY_MAX(DMAX),
        .STEP_DIV(SD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tgt      (tgt),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .duty     (duty),
        .busy     (busy),
        .at_target(at_target),
        .clamped  (clamped)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: duty moves on an absolute schedule of edge numbers, one LSB per entry.
    int m_duty = 0;
    int m_tgt = 0;
    int m_next = 0;
    int edge_no = 0;
    bit m_busy = 1'b0;
    bit m_clamped = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    function automatic bit ready_exp();
`ifdef DUTY_RAMP_RETARGET_EN
        return 1'b1;
`else
        return !m_busy;
`endif
    endfunction

    function automatic int toward(input int from, input int to);
        return (from < to) ? from + 1 : from - 1;
    endfunction

    task automatic model_reset();
        m_duty    = 0;
        m_tgt     = 0;
        m_busy    = 1'b0;
        m_clamped = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int t);
        bit acc;
        int ts;
        acc = v && ready_exp();
        edge_no++;
        m_clamped = acc && (t > DMAX);
        ts = (t > DMAX) ? DMAX : t;
        if (acc && !m_busy) begin
            m_tgt = ts;
            if (ts != m_duty) begin
                m_busy = 1'b1;
                m_next = edge_no + SD;
            end
        end else if (acc) begin
            m_tgt = ts;
            if (ts == m_duty) begin
                m_busy = 1'b0;
            end else if (edge_no == m_next) begin
                m_duty = toward(m_duty, ts);
                m_next += SD;
                if (m_duty == ts) m_busy = 1'b0;
            end
        end else if (m_busy && edge_no == m_next) begin
            m_duty = toward(m_duty, m_tgt);
            m_next += SD;
            if (m_duty == m_tgt) m_busy = 1'b0;
        end
    endtask

    task automatic check_all();
        check("duty", 32'(duty), 32'(m_duty));
        check("tgt_ready", 32'(tgt_ready), 32'(ready_exp()));
        check("busy", 32'(busy), 32'(m_busy));
        check("at_target", 32'(at_target), 32'(!m_busy));
        check("clamped", 32'(clamped), 32'(m_clamped));
    endtask

    task automatic cycle(input bit v, input int t);
        @(negedge clk);
        check_all();
        tgt_valid = v;
        tgt = DW'(t);
        model_edge(v, t);
    endtask

    task automatic wait_duty(input int val);
        for (int i = 0; i < 200 && m_duty != val; i++) cycle(1'b0, 0);
        @(negedge clk);
        check("reach_duty", 32'(duty), 32'(val));
        check_all();
        tgt_valid = 1'b0;
        model_edge(1'b0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        model_edge(1'b0, 0);
        repeat (3) cycle(1'b0, 0);

        // Ramp up 0 -> 5, then down to 2 with a held target of 9 arriving mid-ramp.
        cycle(1'b1, 5);
        repeat (24) cycle(1'b0, 0);
        cycle(1'b1, 2);
        repeat (2) cycle(1'b0, 0);
        repeat (12) cycle(1'b1, 9);
        repeat (30) cycle(1'b0, 0);

        // Over-range target clamps to the maximum.
        cycle(1'b1, 15);
        repeat (45) cycle(1'b0, 0);
        cycle(1'b1, 0);
        repeat (45) cycle(1'b0, 0);

        // Asynchronous reset mid-ramp at duty 3.
        cycle(1'b1, 8);
        wait_duty(3);
        @(negedge clk);
        check_all();
        tgt_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_duty", 32'(duty), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(tgt_ready), 32'd1);
        model_reset();
        #1 rst_n = 1'b1;
        model_edge(1'b0, 0);
        repeat (3) cycle(1'b0, 0);

        // Retarget attempt at duty 3 during a 0 -> 8 ramp.
        cycle(1'b1, 8);
        wait_duty(3);
        cycle(1'b1, 1);
        repeat (40) cycle(1'b0, 0);

        repeat (3000) cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));

        @(negedge clk);
        check_all();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
